// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response bus
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    modport master (output req, addr, input ready, rdata);
    modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with stall buffer, redirect/drop handling and IF/ID register
module fetch_unit (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush_d,
    input  logic         pc_src,
    input  logic [31:0]  pc_target,
    fetch_unit_if.master imem,
    output logic         valid_d,
    output logic [31:0]  instr_d,
    output logic [31:0]  pc_d,
    output logic [31:0]  pc_plus4_d,
    output logic [24:0]  imm_data_d
);
    localparam logic [31:0] NOP = 32'h00000013;
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
    state_t state;
    logic [31:0] fetch_pc, redirect_pc, buf_instr, buf_pc;
    logic fetch_load, hold_load;
    assign fetch_load = state == FETCH && imem.ready && !pc_src && !stall;
    assign hold_load = state == HOLD && !pc_src && !stall;
    assign imem.req = state != HOLD;
    assign imem.addr = {fetch_pc[31:2], 2'b00};
    assign imm_data_d = instr_d[31:7];
    // fetch sequencing: advance, park a response while stalled, or drop a stale response after a redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            fetch_pc <= '0;
            redirect_pc <= '0;
            buf_instr <= '0;
            buf_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem.ready) begin
                        fetch_pc <= pc_src ? pc_target : fetch_pc + 32'd4;
                        if (!pc_src && stall) begin
                            buf_instr <= imem.rdata;
                            buf_pc <= fetch_pc;
                            state <= HOLD;
                        end
                    end else if (pc_src) begin
                        redirect_pc <= pc_target;
                        state <= DROP;
                    end
                end
                HOLD: begin
                    if (pc_src) begin
                        fetch_pc <= pc_target;
                        state <= FETCH;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (imem.ready) begin
                        fetch_pc <= pc_src ? pc_target : redirect_pc;
                        state <= FETCH;
                    end else if (pc_src) begin
                        redirect_pc <= pc_target;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
    // IF/ID register: flush beats stall beats load, otherwise a bubble
    always_ff @(posedge clk) begin
        if (rst || flush_d) begin
            valid_d <= 1'b0;
            instr_d <= NOP;
            pc_d <= '0;
            pc_plus4_d <= '0;
        end else if (!stall) begin
            if (fetch_load || hold_load) begin
                valid_d <= 1'b1;
                instr_d <= fetch_load ? imem.rdata : buf_instr;
                pc_d <= fetch_load ? fetch_pc : buf_pc;
                pc_plus4_d <= (fetch_load ? fetch_pc : buf_pc) + 32'd4;
            end else begin
                valid_d <= 1'b0;
                instr_d <= NOP;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle vector table with an instruction scoreboard for fetch_unit
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst, stall, flush_d, pc_src;
    logic [31:0] pc_target;
    logic valid_d;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic [24:0] imm_data_d;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic r, s, f, p, y;
        logic [31:0] t;
        logic er;
        logic [31:0] ea;
        logic ev;
        logic [31:0] epc;
        logic ld;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc, pc4;
    } exp_t;

    vec_t v[$];
    exp_t sb[$];

    fetch_unit_if bus();

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_d(flush_d), .pc_src(pc_src),
        .pc_target(pc_target), .imem(bus), .valid_d(valid_d), .instr_d(instr_d),
        .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .imm_data_d(imm_data_d)
    );

    always #5 clk = ~clk;

    // memory returns a word tagged by its address
    function automatic logic [31:0] tag(input logic [31:0] a);
        return {~a[31:16], a[15:0]};
    endfunction

    assign bus.rdata = tag(bus.addr);

    function automatic vec_t mk(input logic r, s, f, p, y, input logic [31:0] t,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] epc, input logic ld);
        vec_t x;
        x.r = r; x.s = s; x.f = f; x.p = p; x.y = y; x.t = t;
        x.er = er; x.ea = ea; x.ev = ev; x.epc = epc; x.ld = ld;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] tg;
        //            r  s  f  p  y  target        req addr         vld pc_d        ld
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h0,        1, 32'h0,        1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h4,        1, 32'h4,        1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h8,        1, 32'h8,        1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'hC,        1, 32'hC,        1));
        v.push_back(mk(1, 0, 0, 0, 1, 0,            1, 32'h10,       0, 32'h0,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h0,        1, 32'h0,        1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h4,        1, 32'h4,        1));
        v.push_back(mk(0, 1, 0, 0, 1, 0,            1, 32'h8,        1, 32'h4,        0));
        v.push_back(mk(0, 1, 0, 0, 0, 0,            0, 32'hC,        1, 32'h4,        0));
        v.push_back(mk(0, 1, 0, 0, 0, 0,            0, 32'hC,        1, 32'h4,        0));
        v.push_back(mk(0, 0, 0, 0, 0, 0,            0, 32'hC,        1, 32'h8,        1));
        v.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'hC,        0, 32'h8,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'hC,        1, 32'hC,        1));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h100,      1, 32'h10,       0, 32'hC,        0));
        v.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h10,       0, 32'hC,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h10,       0, 32'hC,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h100,      1, 32'h100,      1));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h200,      1, 32'h104,      0, 32'h100,      0));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h300,      1, 32'h104,      0, 32'h100,      0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h104,      0, 32'h100,      0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h300,      1, 32'h300,      1));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h400,      1, 32'h304,      0, 32'h300,      0));
        v.push_back(mk(0, 0, 0, 1, 1, 32'h600,      1, 32'h304,      0, 32'h300,      0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h600,      1, 32'h600,      1));
        v.push_back(mk(0, 1, 1, 0, 1, 0,            1, 32'h604,      0, 32'h0,        0));
        v.push_back(mk(0, 0, 0, 0, 0, 0,            0, 32'h608,      1, 32'h604,      1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h608,      1, 32'h608,      1));
        v.push_back(mk(0, 0, 1, 0, 1, 0,            1, 32'h60C,      0, 32'h0,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h610,      1, 32'h610,      1));
        v.push_back(mk(0, 1, 0, 1, 1, 32'h700,      1, 32'h614,      1, 32'h610,      0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h700,      1, 32'h700,      1));
        v.push_back(mk(0, 1, 0, 0, 1, 0,            1, 32'h704,      1, 32'h700,      0));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h800,      0, 32'h708,      0, 32'h700,      0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h800,      1, 32'h800,      1));
        v.push_back(mk(0, 0, 0, 1, 1, 32'h903,      1, 32'h804,      0, 32'h800,      0));
        v.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h900,      0, 32'h800,      0));
        v.push_back(mk(0, 0, 0, 1, 1, 32'hFFFFFFF8, 1, 32'h900,      0, 32'h800,      0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'hFFFFFFF8, 1, 32'hFFFFFFF8, 1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h0,        1, 32'h0,        1));
        v.push_back(mk(0, 1, 0, 0, 1, 0,            1, 32'h4,        1, 32'h0,        0));
        v.push_back(mk(1, 1, 0, 0, 1, 0,            0, 32'h8,        0, 32'h0,        0));
        v.push_back(mk(0, 0, 0, 0, 0, 0,            1, 32'h0,        0, 32'h0,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h0,        1, 32'h0,        1));
        v.push_back(mk(0, 0, 0, 1, 0, 32'h100,      1, 32'h4,        0, 32'h0,        0));
        v.push_back(mk(1, 0, 0, 0, 1, 0,            1, 32'h4,        0, 32'h0,        0));
        v.push_back(mk(0, 0, 0, 0, 1, 0,            1, 32'h0,        1, 32'h0,        1));

        rst = 1'b1; stall = 1'b0; flush_d = 1'b0; pc_src = 1'b0; pc_target = '0; bus.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_d", {31'b0, valid_d}, 32'd0);
        chk("reset instr_d", instr_d, 32'h00000013);
        chk("reset pc_d", pc_d, 32'd0);
        chk("reset pc_plus4_d", pc_plus4_d, 32'd0);
        chk("reset imem_req", {31'b0, bus.req}, 32'd1);
        chk("reset imem_addr", bus.addr, 32'd0);

        for (int i = 0; i < v.size(); i++) begin
            rst = v[i].r; stall = v[i].s; flush_d = v[i].f; pc_src = v[i].p;
            pc_target = v[i].t; bus.ready = v[i].y;
            if (v[i].ld) begin
                e.instr = tag(v[i].epc);
                e.pc = v[i].epc;
                e.pc4 = v[i].epc + 32'd4;
                sb.push_back(e);
            end
            #1;
            chk($sformatf("v%0d imem_req", i), {31'b0, bus.req}, {31'b0, v[i].er});
            chk($sformatf("v%0d imem_addr", i), bus.addr, v[i].ea);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d valid_d", i), {31'b0, valid_d}, {31'b0, v[i].ev});
            chk($sformatf("v%0d pc_d", i), pc_d, v[i].epc);
            if (v[i].ld) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d scoreboard: got empty queue expected an entry", i);
                end else begin
                    e = sb.pop_front();
                    tg = e.instr;
                    chk($sformatf("v%0d instr_d", i), instr_d, e.instr);
                    chk($sformatf("v%0d pc_plus4_d", i), pc_plus4_d, e.pc4);
                    chk($sformatf("v%0d imm_data_d", i), {7'b0, imm_data_d}, {7'b0, tg[31:7]});
                end
            end else if (!v[i].ev) begin
                chk($sformatf("v%0d bubble instr_d", i), instr_d, 32'h00000013);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk sampled on rising edge; rst synchronous active-high.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hazard unit: hold IF/ID register
- flush_d  in  1  kill IF/ID contents (insert bubble)
- pc_src  in  1  redirect request (taken branch/jump)
- pc_target  in  32  redirect address
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request address, word aligned
- imem_ready  in  1  response valid this cycle
- imem_rdata  in  32  instruction word
- valid_d  out  1  IF/ID holds a real instruction
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID instruction address
- pc_plus4_d  out  32  pc_d + 4
- imm_data_d  out  25  instr_d[31:7], feeds immediate extender data input

Function
REQ-003 SHALL implement states FETCH, HOLD, DROP; registers fetch_pc, redirect_pc, buf_instr, buf_pc.
REQ-004 FETCH: imem_req=1, imem_addr=fetch_pc. DROP: imem_req=1, imem_addr=fetch_pc (stale, unchanged). HOLD: imem_req=0.
REQ-005 imem_addr SHALL stay stable while imem_req=1 until imem_ready is seen.
REQ-006 FETCH, imem_ready=1, pc_src=0, stall=0: IF/ID <= {imem_rdata, fetch_pc, fetch_pc+4}, valid_d<=1, fetch_pc<=fetch_pc+4, stay FETCH; back-to-back one instruction per cycle when memory is ready each cycle.
REQ-007 FETCH, imem_ready=1, pc_src=0, stall=1: buf_instr<=imem_rdata, buf_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go HOLD; IF/ID unchanged.
REQ-008 HOLD, stall=0, pc_src=0: IF/ID <= {buf_instr, buf_pc, buf_pc+4}, valid_d<=1, go FETCH.
REQ-009 FETCH, imem_ready=1, pc_src=1: response discarded, fetch_pc<=pc_target, stay FETCH.
REQ-010 FETCH, imem_ready=0, pc_src=1: redirect_pc<=pc_target, go DROP.
REQ-011 DROP, imem_ready=1: response discarded, fetch_pc<=redirect_pc (or pc_target if pc_src=1 same cycle), go FETCH.
REQ-012 DROP, imem_ready=0, pc_src=1: redirect_pc<=pc_target (latest redirect wins), stay DROP.
REQ-013 HOLD, pc_src=1: buffer discarded, fetch_pc<=pc_target, go FETCH.
REQ-014 pc_target SHALL be used as given; bits [1:0] ignored (forced 0 on imem_addr).
REQ-015 IF/ID priority per cycle: flush_d (valid_d<=0, instr_d<=32'h00000013, pc_d/pc_plus4_d<=0) > stall (hold all) > load (REQ-006/008) > bubble (valid_d<=0, instr_d<=32'h00000013).
REQ-016 flush_d without pc_src SHALL only affect IF/ID; fetch state/fetch_pc unaffected.
REQ-017 pc_src with stall=1 SHALL still redirect fetch; IF/ID held unless flush_d.
REQ-018 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-019 imm_data_d SHALL be combinational from instr_d[31:7]; all other outputs registered or state-decoded only.

Reset
REQ-020 rst=1 at clock edge: state<=FETCH, fetch_pc<=0, redirect_pc<=0, buffers<=0, valid_d<=0, instr_d<=32'h00000013, pc_d<=0, pc_plus4_d<=0; overrides all other inputs.
REQ-021 rst mid-transaction (DROP/HOLD, or outstanding request) SHALL abandon it; first post-reset request is addr 0; response ready in reset cycle ignored.
REQ-022 After reset deassertion imem_req=1, imem_addr=0 in the first cycle.

Verification
REQ-023 Scenario 1: reset, imem_ready=1 every cycle, rdata=addr-tagged words -> valid_d=1 with pc_d=0,4,8,12 on consecutive cycles; imm_data_d=instr_d[31:7].
REQ-024 Scenario 2: response at addr 8 with stall=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID holds pc 4; stall release -> pc_d=8 next cycle, then request addr 12.
REQ-025 Scenario 3: imem_ready=0 at addr 16, pc_src=1, pc_target=0x100 -> DROP, imem_addr stays 16; ready pulse discarded (valid_d=0); next request addr 0x100.
REQ-026 Scenario 4: two redirects (0x200, then 0x300) during DROP -> fetch resumes at 0x300 only.
REQ-027 Scenario 5: flush_d=1 and stall=1 same cycle -> valid_d=0, instr_d=32'h00000013; fetch continues.
REQ-028 Scenario 6: fetch_pc=32'hFFFFFFFC accepted -> next imem_addr=0; rst asserted in HOLD -> next imem_addr=0, valid_d=0.
